// File: rtl/core_csr_pkg.sv
// Shared types and constants for the CSR fabric.
// Holds the access FSM state enum, error read pattern and select-width helper.
package core_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } csr_state_e;

    localparam logic [31:0] CSR_ERR_DATA = 32'hBADC_0DE5;

    function automatic int sel_width(input int msb, input int lsb);
        return msb - lsb + 1;
    endfunction

endpackage

// File: rtl/core_csr_fabric_if.sv
// Avalon-MM CSR port between the HPS-side master and the fabric.
// Ports: address/write/read/writedata from master; readdata/waitrequest back.
interface core_csr_fabric_if #(
    parameter int ADDR_WIDTH = 18
);
    import core_csr_pkg::*;

    logic [ADDR_WIDTH-1:0] address;
    logic                  write;
    logic                  read;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic                  waitrequest;

    modport master (
        output address, write, read, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, read, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/core_csr_timeout.sv
// Loadable up-counter bounding how long the fabric waits for a slave ack.
// Ports: clk, reset_n, load (clear), en (count), tc (last allowed cycle).
module core_csr_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Count is 0 in the strobe cycle, so TIMEOUT_CYCLES-1 marks the
    // final cycle in which an ack is still accepted.
    assign tc = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/core_csr_fabric.sv
// CSR fabric: decodes the select field, strobes one slave, waits for its ack.
// Ports: clk, reset_n, avs (Avalon slave), slv_* fan-out, err_* sticky status.
module core_csr_fabric
    import core_csr_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 18,
    parameter int          SEL_MSB        = 17,
    parameter int          SEL_LSB        = 15,
    parameter int          NUM_SLAVES     = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = CSR_ERR_DATA
) (
    input  logic                       clk,
    input  logic                       reset_n,
    core_csr_fabric_if.slave           avs,
    output logic [SEL_LSB-1:0]         slv_address,
    output logic [31:0]                slv_writedata,
    output logic [NUM_SLAVES-1:0]      slv_write,
    output logic [NUM_SLAVES-1:0]      slv_read,
    input  logic [32*NUM_SLAVES-1:0]   slv_readdata,
    input  logic [NUM_SLAVES-1:0]      slv_ack,
    input  logic                       err_clear,
    output logic                       err_sticky,
    output logic [ADDR_WIDTH-1:0]      err_addr,
    output logic                       err_timeout
);
    localparam int SW = sel_width(SEL_MSB, SEL_LSB);

    csr_state_e state_q, state_d;

    logic [SW-1:0]         req_sel;
    logic [NUM_SLAVES-1:0] req_oh;
    logic [NUM_SLAVES-1:0] sel_oh_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  is_wr_q;
    logic                  mapped;
    logic                  busy;
    logic                  ack_hit;
    logic                  cnt_load;
    logic                  cnt_tc;
    logic                  done_ok;
    logic                  err_now;
    logic [31:0]           rd_mux;

    assign req_sel = avs.address[SEL_MSB:SEL_LSB];

    // Select decoded to one-hot; an unmapped select yields all zeros.
    always_comb begin
        req_oh = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            req_oh[i] = (int'(req_sel) == i);
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            rd_mux |= slv_readdata[32*i +: 32] & {32{sel_oh_q[i]}};
        end
    end

    assign mapped  = |sel_oh_q;
    assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign ack_hit = |(slv_ack & sel_oh_q);
    assign done_ok = busy && ack_hit;
    assign err_now = ((state_q == ST_ISSUE) && !mapped)
                   || (busy && mapped && !ack_hit && cnt_tc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (avs.write || avs.read) begin
                    state_d  = ST_ISSUE;
                    cnt_load = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (done_ok || err_now) state_d = ST_DONE;
                else                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_ok || err_now) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    core_csr_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (cnt_load),
        .en     (busy),
        .tc     (cnt_tc)
    );

    assign avs.waitrequest = (state_q != ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= '0;
            is_wr_q       <= 1'b0;
            sel_oh_q      <= '0;
            slv_address   <= '0;
            slv_writedata <= '0;
            slv_write     <= '0;
            slv_read      <= '0;
            avs.readdata  <= '0;
        end else begin
            slv_write <= '0;
            slv_read  <= '0;
            if ((state_q == ST_IDLE) && (avs.write || avs.read)) begin
                addr_q        <= avs.address;
                is_wr_q       <= avs.write;
                sel_oh_q      <= req_oh;
                slv_address   <= avs.address[SEL_LSB-1:0];
                slv_writedata <= avs.writedata;
                if (avs.write) slv_write <= req_oh;
                else           slv_read  <= req_oh;
            end
            if (done_ok) begin
                avs.readdata <= is_wr_q ? 32'h0 : rd_mux;
            end else if (err_now) begin
                avs.readdata <= ERR_DATA;
            end
        end
    end

    // A new error beats a simultaneous clear and reloads the fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky  <= 1'b0;
            err_addr    <= '0;
            err_timeout <= 1'b0;
        end else if (err_now) begin
            err_sticky <= 1'b1;
            if (!err_sticky || err_clear) begin
                err_addr    <= addr_q;
                err_timeout <= mapped;
            end
        end else if (err_clear) begin
            err_sticky  <= 1'b0;
            err_addr    <= '0;
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_csr_fabric.sv
// Self-checking bench for core_csr_fabric with a transaction-level model.
// Ports: none; drives the Avalon interface and emulates four slaves.
module tb_core_csr_fabric;

    localparam int          AW  = 18;
    localparam int          NS  = 4;
    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hBADC_0DE5;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [14:0]         slv_address;
    logic [31:0]         slv_writedata;
    logic [NS-1:0]       slv_write;
    logic [NS-1:0]       slv_read;
    logic [32*NS-1:0]    slv_readdata;
    logic [NS-1:0]       slv_ack;
    logic                err_clear;
    logic                err_sticky;
    logic [AW-1:0]       err_addr;
    logic                err_timeout;

    core_csr_fabric_if #(.ADDR_WIDTH(AW)) avs_if ();

    core_csr_fabric #(
        .ADDR_WIDTH    (AW),
        .SEL_MSB       (17),
        .SEL_LSB       (15),
        .NUM_SLAVES    (NS),
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (ERR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs          (avs_if),
        .slv_address  (slv_address),
        .slv_writedata(slv_writedata),
        .slv_write    (slv_write),
        .slv_read     (slv_read),
        .slv_readdata (slv_readdata),
        .slv_ack      (slv_ack),
        .err_clear    (err_clear),
        .err_sticky   (err_sticky),
        .err_addr     (err_addr),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Transaction model state.
    int          cyc = 0;
    bit          act = 0;
    int          t0, exp_done, exp_sel;
    bit          exp_map, exp_wr, exp_err, exp_to;
    logic [31:0] exp_rdata, exp_wd;
    logic [AW-1:0] exp_addr;
    bit          m_sticky = 0;
    logic [AW-1:0] m_addr = '0;
    bit          m_to = 0;

    int          obs_done;
    logic [31:0] obs_rdata;
    logic [NS-1:0] obs_wstb, obs_rstb;
    logic [14:0] obs_saddr;

    logic [32*NS-1:0] dflt_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act      = 0;
            m_sticky = 0;
            m_addr   = '0;
            m_to     = 0;
        end else begin
            cyc = cyc + 1;
            if (act && cyc == exp_done && exp_err) begin
                if (!m_sticky || err_clear) begin
                    m_addr = exp_addr;
                    m_to   = exp_to;
                end
                m_sticky = 1;
            end else if (err_clear) begin
                m_sticky = 0;
                m_addr   = '0;
                m_to     = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [NS-1:0] ew, er;
        if (!reset_n) begin
            chk("rst_wait",  avs_if.waitrequest, 1);
            chk("rst_rdata", avs_if.readdata, 0);
            chk("rst_swr",   slv_write, 0);
            chk("rst_srd",   slv_read, 0);
            chk("rst_saddr", slv_address, 0);
            chk("rst_swd",   slv_writedata, 0);
            chk("rst_stky",  err_sticky, 0);
            chk("rst_eaddr", err_addr, 0);
            chk("rst_eto",   err_timeout, 0);
        end else begin
            ew = '0;
            er = '0;
            chk("wait", avs_if.waitrequest, !(act && cyc == exp_done));
            if (act && cyc == exp_done) chk("rdata", avs_if.readdata, exp_rdata);
            if (act && cyc == t0 + 1 && exp_map) begin
                if (exp_wr) ew[exp_sel] = 1'b1;
                else        er[exp_sel] = 1'b1;
                chk("saddr", slv_address, exp_addr[14:0]);
                if (exp_wr) chk("swd", slv_writedata, exp_wd);
            end
            chk("swr",   slv_write, ew);
            chk("srd",   slv_read, er);
            chk("stky",  err_sticky, m_sticky);
            chk("eaddr", err_addr, m_addr);
            chk("eto",   err_timeout, m_to);
        end
    end

    task automatic access(input logic [AW-1:0] addr, input logic wr,
                          input logic rd, input logic [31:0] wd,
                          input int ack_k, input int ack_s,
                          input logic [31:0] ack_d, input int spur_k,
                          input int spur_s, input int clr_k);
        int sel, off, last;
        @(posedge clk); #1;
        sel = int'(addr[17:15]);
        exp_map = (sel < NS);
        exp_to  = 0;
        if (!exp_map) begin
            off = 2; exp_err = 1; exp_rdata = ERR;
        end else if (ack_k >= 1 && ack_k <= TO && ack_s == sel) begin
            off = ack_k + 1; exp_err = 0; exp_rdata = wr ? 32'h0 : ack_d;
        end else begin
            off = TO + 1; exp_err = 1; exp_to = 1; exp_rdata = ERR;
        end
        exp_wr = wr; exp_sel = sel; exp_addr = addr; exp_wd = wd;
        t0 = cyc; exp_done = cyc + off; act = 1;
        obs_done = -1; obs_rdata = 'x;
        avs_if.address = addr; avs_if.write = wr;
        avs_if.read = rd; avs_if.writedata = wd;
        last = off + 1;
        if (ack_k + 1 > last) last = ack_k + 1;
        if (spur_k + 1 > last) last = spur_k + 1;
        for (int j = 1; j <= last; j++) begin
            @(posedge clk); #1;
            if (j == off + 1) begin
                avs_if.write = 0; avs_if.read = 0;
            end
            slv_ack = '0;
            slv_readdata = dflt_rd;
            err_clear = (j == clr_k);
            if (j == ack_k) begin
                slv_ack[ack_s] = 1'b1;
                slv_readdata[32*ack_s +: 32] = ack_d;
            end
            if (j == spur_k) slv_ack[spur_s] = 1'b1;
            if (j == 1) begin
                obs_wstb = slv_write; obs_rstb = slv_read;
                obs_saddr = slv_address;
            end
            if (obs_done < 0 && !avs_if.waitrequest) begin
                obs_done = j; obs_rdata = avs_if.readdata;
            end
        end
        avs_if.write = 0; avs_if.read = 0;
        slv_ack = '0; err_clear = 0; slv_readdata = dflt_rd;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; err_clear = 1;
        @(posedge clk); #1; err_clear = 0;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) dflt_rd[32*i +: 32] = 32'h5A5A_0000 + i;
        slv_readdata = dflt_rd;
        slv_ack = '0; err_clear = 0;
        avs_if.address = '0; avs_if.write = 0;
        avs_if.read = 0; avs_if.writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        repeat (2) @(posedge clk);

        // Write slave 1, ack in strobe cycle.
        access(18'h0_8004, 1, 0, 32'h1234_5678, 1, 1, 0, 0, 0, 0);
        chk("w_done", obs_done, 2);
        chk("w_stb", obs_wstb, 4'b0010);
        chk("w_saddr", obs_saddr, 15'h4);

        // Read slave 2, ack after 10 cycles.
        access(18'h1_0010, 0, 1, 0, 10, 2, 32'hCAFE_F00D, 0, 0, 0);
        chk("r_done", obs_done, 11);
        chk("r_data", obs_rdata, 32'hCAFE_F00D);
        chk("r_stb", obs_rstb, 4'b0100);

        // Read slave 3 with no ack, late ack after timeout.
        access(18'h1_8020, 0, 1, 0, 18, 3, 32'h1111_2222, 0, 0, 0);
        chk("to_done", obs_done, 17);
        chk("to_data", obs_rdata, ERR);
        chk("to_stky", err_sticky, 1);
        chk("to_eto", err_timeout, 1);
        chk("to_eaddr", err_addr, 18'h1_8020);

        pulse_clear();
        chk("clr1_stky", err_sticky, 0);

        // Unmapped select 5.
        access(18'h2_8008, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("um_done", obs_done, 2);
        chk("um_data", obs_rdata, ERR);
        chk("um_stb", obs_rstb, 4'b0000);
        chk("um_eto", err_timeout, 0);
        chk("um_eaddr", err_addr, 18'h2_8008);

        // Second error keeps first address.
        access(18'h3_8000, 1, 0, 32'h5, 0, 0, 0, 0, 0, 0);
        chk("um2_eaddr", err_addr, 18'h2_8008);

        // Clear together with a new error: error wins, fields reload.
        access(18'h3_0004, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("cw_stky", err_sticky, 1);
        chk("cw_eaddr", err_addr, 18'h3_0004);

        pulse_clear();
        chk("clr2_stky", err_sticky, 0);
        chk("clr2_eaddr", err_addr, 0);
        chk("clr2_eto", err_timeout, 0);

        // Write and read together, spurious ack from slave 2.
        access(18'h0_0010, 1, 1, 32'hA5A5_0001, 3, 0, 32'h7777_7777, 1, 2, 0);
        chk("wr_done", obs_done, 4);
        chk("wr_wstb", obs_wstb, 4'b0001);
        chk("wr_rstb", obs_rstb, 4'b0000);
        chk("wr_data", obs_rdata, 0);

        // Ack on the last allowed cycle still succeeds.
        access(18'h0_800C, 0, 1, 0, TO, 1, 32'h0BAD_F00D, 0, 0, 0);
        chk("edge_done", obs_done, 17);
        chk("edge_data", obs_rdata, 32'h0BAD_F00D);
        chk("edge_stky", err_sticky, 0);

        // Reset in WAIT.
        @(posedge clk); #1;
        exp_map = 1; exp_wr = 0; exp_sel = 0; exp_err = 1; exp_to = 1;
        exp_addr = 18'h0_0040; exp_rdata = ERR;
        t0 = cyc; exp_done = cyc + TO + 1; act = 1;
        avs_if.address = 18'h0_0040; avs_if.read = 1;
        repeat (3) @(posedge clk);
        #1 reset_n = 0;
        #1 chk("mid_wait", avs_if.waitrequest, 1);
        chk("mid_srd", slv_read, 0);
        repeat (2) @(posedge clk);
        #1 avs_if.read = 0;
        reset_n = 1;
        repeat (5) @(posedge clk);
        #1 chk("post_srd", slv_read, 0);

        // Normal access after reset.
        access(18'h0_8010, 0, 1, 0, 2, 1, 32'h600D_BEEF, 0, 0, 0);
        chk("post_done", obs_done, 3);
        chk("post_data", obs_rdata, 32'h600D_BEEF);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
